// File: rtl/periferico_hs_rx_fifo_pkg.sv
// Package for the peripheral-side handshake receiver.
// Holds the handshake state encoding shared by the receiver FSM and any
// block that needs to decode it (the CPU-side sender uses the same values).
package periferico_hs_rx_fifo_pkg;

    // Two-state 4-phase receiver: waiting for a request, or holding ack.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } hs_state_e;

    // Narrowest legal synchroniser depth.
    localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/periferico_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst      clock, synchronous active-high reset (pointers/occupancy only)
//   push, din     write request and word; ignored while full
//   pop           read request; ignored while empty
//   dout          head of FIFO, meaningful while empty=0
//   full, empty   occupancy flags derived from the registered level
//   level         occupancy 0..DEPTH
module periferico_sync_fifo #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic              do_push;
    logic              do_pop;

    // Flags come from the registered count, so a pop in the same cycle does
    // not make room for a push until the next cycle.
    assign full    = (cnt == FULL_LVL);
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign level   = cnt;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; stale entries are never visible because
    // empty gates the head.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/periferico_hs_rx_fifo.sv
// Peripheral-side receiver for the CPU's 4-phase send/ack handshake.
// Synchronises send, captures one word per handshake into a FIFO, withholds
// ack while the FIFO is full, and presents words through an FWFT valid/ready
// port.
// Ports:
//   clk1, rst1   peripheral clock, synchronous active-high reset
//   send         CPU request, asynchronous to clk1
//   dataInput    CPU word, held stable while send=1
//   ack          registered acknowledge back to the CPU
//   out_valid    FIFO not empty
//   out_data     FIFO head
//   out_ready    consumer takes the head this cycle
//   level        FIFO occupancy 0..DEPTH
//   stalled      request seen but FIFO full
//   words_rcvd   accepted-word counter, wraps silently
module periferico_hs_rx_fifo
    import periferico_hs_rx_fifo_pkg::*;
#(
    parameter int DATA_W      = 2,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                     clk1,
    input  logic                     rst1,
    input  logic                     send,
    input  logic [DATA_W-1:0]        dataInput,
    output logic                     ack,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     stalled,
    output logic [CNT_W-1:0]         words_rcvd
);

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   send_s;
    hs_state_e              state;
    hs_state_e              state_nx;
    logic                   push;
    logic                   full;
    logic                   empty;

    // Stage boundary: send crosses into clk1 through SYNC_STAGES flops.
    always_ff @(posedge clk1) begin
        if (rst1) sync_p <= '0;
        else      sync_p <= {sync_p[SYNC_STAGES-2:0], send};
    end

    assign send_s = sync_p[SYNC_STAGES-1];

    // Stage boundary: handshake FSM and ack register.
    always_ff @(posedge clk1) begin
        if (rst1) begin
            state <= S_IDLE;
            ack   <= 1'b0;
        end else begin
            state <= state_nx;
            ack   <= (state_nx == S_ACK);
        end
    end

    // One push per handshake: the push only happens on the IDLE->ACK step,
    // and the FSM cannot leave ACK until send has been seen low.
    always_comb begin
        state_nx = state;
        push     = 1'b0;
        stalled  = 1'b0;
        case (state)
            S_IDLE: begin
                if (send_s) begin
                    if (!full) begin
                        push     = 1'b1;
                        state_nx = S_ACK;
                    end else begin
                        stalled  = 1'b1;
                    end
                end
            end
            S_ACK: begin
                if (!send_s) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst1)      words_rcvd <= '0;
        else if (push) words_rcvd <= words_rcvd + CNT_W'(1);
    end

    periferico_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk1),
        .rst   (rst1),
        .push  (push),
        .din   (dataInput),
        .pop   (out_ready),
        .dout  (out_data),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign out_valid = ~empty;

endmodule

// File: tb/tb_periferico_hs_rx_fifo.sv
// Bench for periferico_hs_rx_fifo: directed handshake scenarios followed by a
// randomized CPU/consumer phase, all checked against a queue-based model.
module tb_periferico_hs_rx_fifo;

    localparam int DATA_W      = 2;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 3;
    localparam int LW          = $clog2(DEPTH) + 1;

    logic              clk1 = 1'b0;
    logic              rst1 = 1'b1;
    logic              send = 1'b0;
    logic [DATA_W-1:0] dataInput = '0;
    logic              out_ready = 1'b0;
    logic              ack;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [LW-1:0]     level;
    logic              stalled;
    logic [CNT_W-1:0]  words_rcvd;

    always #5 clk1 = ~clk1;

    periferico_hs_rx_fifo #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk1       (clk1),
        .rst1       (rst1),
        .send       (send),
        .dataInput  (dataInput),
        .ack        (ack),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .level      (level),
        .stalled    (stalled),
        .words_rcvd (words_rcvd)
    );

    int                n_cmp = 0;
    int                n_bad = 0;
    logic [DATA_W-1:0] model_q[$];
    int unsigned       acc = 0;
    logic              ack_prev = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and update the model: a word is accepted whenever ack
    // rises, a pop happens whenever the consumer was ready and the model held
    // data. Then compare every visible output against the model.
    task automatic tick();
        bit do_pop;
        @(posedge clk1);
        #1;
        if (rst1) begin
            model_q.delete();
            acc = 0;
        end else begin
            do_pop = out_ready && (model_q.size() != 0);
            if (do_pop) void'(model_q.pop_front());
            if (ack && !ack_prev) begin
                model_q.push_back(dataInput);
                acc++;
            end
        end
        ack_prev = ack;
        check_val("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() != 0});
        check_val("level", 32'(level), 32'(model_q.size()));
        check_val("words_rcvd", 32'(words_rcvd), acc % (1 << CNT_W));
        if (model_q.size() != 0) check_val("out_data", 32'(out_data), 32'(model_q[0]));
    endtask

    task automatic wait_ack(input logic val, input int maxc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (ack !== val && n < maxc);
        if (ack !== val) check_val("ack_timeout", {31'd0, ack}, {31'd0, val});
    endtask

    task automatic xfer(input logic [DATA_W-1:0] w);
        int n;
        dataInput = w;
        send = 1'b1;
        wait_ack(1'b1, 20, n);
        send = 1'b0;
        wait_ack(1'b0, 20, n);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2 && model_q.size() != 0; i++) tick();
        out_ready = 1'b0;
        check_val("drained_level", 32'(level), 32'd0);
    endtask

    initial begin
        int n;
        int gap;
        logic [DATA_W-1:0] exp3 [4];
        logic [DATA_W-1:0] w;

        // Reset held for five cycles.
        rst1 = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_val("rst_ack", {31'd0, ack}, 32'd0);
        check_val("rst_stalled", {31'd0, stalled}, 32'd0);
        check_val("rst_level", 32'(level), 32'd0);
        rst1 = 1'b0;
        tick();

        // Single transfer: ack after SYNC_STAGES+1 edges each way.
        dataInput = 2'b10;
        send = 1'b1;
        wait_ack(1'b1, 10, n);
        check_val("t2_ack_rise_lat", 32'(n), 32'(SYNC_STAGES + 1));
        check_val("t2_out_data", 32'(out_data), 32'h2);
        check_val("t2_level", 32'(level), 32'd1);
        send = 1'b0;
        wait_ack(1'b0, 10, n);
        check_val("t2_ack_fall_lat", 32'(n), 32'(SYNC_STAGES + 1));
        drain();

        // Five words into a four-deep FIFO, consumer idle.
        for (int i = 0; i < 4; i++) xfer(DATA_W'(i));
        check_val("t3_level_full", 32'(level), 32'(DEPTH));
        dataInput = 2'd0;
        send = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_val("t3_stalled", {31'd0, stalled}, 32'd1);
        check_val("t3_ack_held", {31'd0, ack}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_ack(1'b1, 4, n);
        send = 1'b0;
        wait_ack(1'b0, 10, n);
        exp3[0] = 2'd1; exp3[1] = 2'd2; exp3[2] = 2'd3; exp3[3] = 2'd0;
        for (int i = 0; i < 4; i++) begin
            check_val("t3_order", 32'(out_data), 32'(exp3[i]));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        check_val("t3_empty", {31'd0, out_valid}, 32'd0);

        // Full FIFO with a continuous consumer: the push lands one cycle
        // after the pop that made room.
        for (int i = 0; i < 4; i++) xfer(DATA_W'($urandom));
        dataInput = DATA_W'($urandom);
        send = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_val("t4_stalled", {31'd0, stalled}, 32'd1);
        out_ready = 1'b1;
        tick();
        check_val("t4_no_push_on_pop", {31'd0, ack}, 32'd0);
        check_val("t4_level_after_pop", 32'(level), 32'(DEPTH - 1));
        tick();
        check_val("t4_push_next", {31'd0, ack}, 32'd1);
        check_val("t4_not_stalled", {31'd0, stalled}, 32'd0);
        send = 1'b0;
        wait_ack(1'b0, 10, n);
        drain();

        // Reset while holding ack with send still high.
        dataInput = 2'd3;
        send = 1'b1;
        wait_ack(1'b1, 10, n);
        rst1 = 1'b1;
        tick();
        check_val("t5_rst_ack", {31'd0, ack}, 32'd0);
        check_val("t5_rst_level", 32'(level), 32'd0);
        rst1 = 1'b0;
        wait_ack(1'b1, 10, n);
        check_val("t5_reack_lat", 32'(n), 32'(SYNC_STAGES + 1));
        check_val("t5_level", 32'(level), 32'd1);
        check_val("t5_word", 32'(out_data), 32'h3);
        send = 1'b0;
        wait_ack(1'b0, 10, n);
        drain();

        // Counter wrap: nine transfers on a 3-bit counter.
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) xfer(DATA_W'($urandom));
        check_val("t6_wrap", 32'(words_rcvd), 32'd1);
        out_ready = 1'b0;
        drain();

        // Randomized CPU with asynchronous send timing and a bursty consumer.
        gap = 0;
        for (int c = 0; c < 600; c++) begin
            #($urandom_range(0, 7));
            out_ready = 1'($urandom_range(0, 1));
            if (!send && !ack && gap == 0) begin
                w = DATA_W'($urandom);
                dataInput = w;
                send = 1'b1;
            end else if (send && ack) begin
                send = 1'b0;
                gap = $urandom_range(0, 3);
            end else if (!send && gap > 0) begin
                gap--;
            end
            tick();
        end
        send = 1'b0;
        out_ready = 1'b0;
        if (ack) wait_ack(1'b0, 10, n);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
